// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and writeback datapath: load extraction/extension,
// writeback select, GRF write port, W->D bypass and retired-instruction counter.
module mem_wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              m_valid,
    input  logic [31:0]       m_pc,
    input  logic              m_reg_we,
    input  logic [4:0]        m_reg_addr,
    input  logic [1:0]        m_wd_sel,
    input  logic [31:0]       m_alu_result,
    input  logic [31:0]       m_mem_rdata,
    input  logic [2:0]        m_load_type,
    input  logic [31:0]       m_hilo_value,
    output logic              grf_we,
    output logic [4:0]        grf_a3,
    output logic [31:0]       grf_wd,
    output logic [31:0]       grf_pc,
    output logic              fwd_valid,
    output logic [4:0]        fwd_addr,
    output logic [31:0]       fwd_data,
    output logic [CNT_W-1:0]  instret
);

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic        w_valid;
    logic [31:0] w_pc;
    logic        w_reg_we;
    logic [4:0]  w_reg_addr;
    logic [1:0]  w_wd_sel;
    logic [31:0] w_alu;
    logic [31:0] w_rdata;
    logic [2:0]  w_ltype;
    logic [31:0] w_hilo;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            w_valid    <= 1'b0;
            w_pc       <= RESET_PC;
            w_reg_we   <= 1'b0;
            w_reg_addr <= 5'd0;
            w_wd_sel   <= 2'd0;
            w_alu      <= 32'd0;
            w_rdata    <= 32'd0;
            w_ltype    <= 3'd0;
            w_hilo     <= 32'd0;
        end else if (!stall) begin
            w_valid    <= m_valid;
            w_pc       <= m_pc;
            w_reg_we   <= m_reg_we;
            w_reg_addr <= m_reg_addr;
            w_wd_sel   <= m_wd_sel;
            w_alu      <= m_alu_result;
            w_rdata    <= m_mem_rdata;
            w_ltype    <= m_load_type;
            w_hilo     <= m_hilo_value;
        end
    end

    // Counts the instruction leaving W, so a flushed or stalled one is not counted.
    always_ff @(posedge clk) begin
        if (reset)
            instret <= '0;
        else if (!flush && !stall && w_valid)
            instret <= instret + 1'b1;
    end

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] wb_data;

    always_comb begin
        load_byte = 8'd0;
        load_half = 16'd0;
        load_data = w_rdata;
        case (w_alu[1:0])
            2'd0:    load_byte = w_rdata[7:0];
            2'd1:    load_byte = w_rdata[15:8];
            2'd2:    load_byte = w_rdata[23:16];
            default: load_byte = w_rdata[31:24];
        endcase
        load_half = w_alu[1] ? w_rdata[31:16] : w_rdata[15:0];
        case (w_ltype)
            LT_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            LT_LBU:  load_data = {24'd0, load_byte};
            LT_LH:   load_data = {{16{load_half[15]}}, load_half};
            LT_LHU:  load_data = {16'd0, load_half};
            LT_LW:   load_data = w_rdata;
            default: load_data = w_rdata;
        endcase
    end

    always_comb begin
        wb_data = w_alu;
        case (w_wd_sel)
            2'b00:   wb_data = w_alu;
            2'b01:   wb_data = load_data;
            2'b10:   wb_data = w_pc + 32'd8;
            default: wb_data = w_hilo;
        endcase
    end

    // $0 is hardwired, so a write to it never reaches the GRF or the bypass.
    assign grf_we    = w_valid & w_reg_we & (w_reg_addr != 5'd0);
    assign grf_a3    = w_reg_addr;
    assign grf_wd    = wb_data;
    assign grf_pc    = w_pc;
    assign fwd_valid = grf_we;
    assign fwd_addr  = grf_a3;
    assign fwd_data  = grf_wd;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, ALU/load/link/HI-LO writeback,
// $0 suppression, stall/flush, reset mid-operation and counter wrap (CNT_W=4 copy).
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        m_valid, m_reg_we;
    logic [31:0] m_pc, m_alu_result, m_mem_rdata, m_hilo_value;
    logic [4:0]  m_reg_addr;
    logic [1:0]  m_wd_sel;
    logic [2:0]  m_load_type;

    logic        grf_we, fwd_valid;
    logic [4:0]  grf_a3, fwd_addr;
    logic [31:0] grf_wd, grf_pc, fwd_data, instret;

    logic        s_grf_we, s_fwd_valid;
    logic [4:0]  s_grf_a3, s_fwd_addr;
    logic [31:0] s_grf_wd, s_grf_pc, s_fwd_data;
    logic [3:0]  s_instret;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_pc(m_pc), .m_reg_we(m_reg_we), .m_reg_addr(m_reg_addr),
        .m_wd_sel(m_wd_sel), .m_alu_result(m_alu_result), .m_mem_rdata(m_mem_rdata),
        .m_load_type(m_load_type), .m_hilo_value(m_hilo_value),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .instret(instret)
    );

    mem_wb_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_pc(m_pc), .m_reg_we(m_reg_we), .m_reg_addr(m_reg_addr),
        .m_wd_sel(m_wd_sel), .m_alu_result(m_alu_result), .m_mem_rdata(m_mem_rdata),
        .m_load_type(m_load_type), .m_hilo_value(m_hilo_value),
        .grf_we(s_grf_we), .grf_a3(s_grf_a3), .grf_wd(s_grf_wd), .grf_pc(s_grf_pc),
        .fwd_valid(s_fwd_valid), .fwd_addr(s_fwd_addr), .fwd_data(s_fwd_data), .instret(s_instret)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] addr,
                         input logic [1:0] sel, input logic [31:0] alu, input logic [2:0] lt);
        m_valid = v; m_reg_we = we; m_reg_addr = addr;
        m_wd_sel = sel; m_alu_result = alu; m_load_type = lt;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        m_pc = 32'h0; m_mem_rdata = 32'h0; m_hilo_value = 32'h0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 3'd0);
        #1;
        step(); step();
        check("rst_we",      {31'd0, grf_we}, 32'd0);
        check("rst_pc",      grf_pc, 32'h0000_3000);
        check("rst_instret", instret, 32'd0);
        check("rst_fwd",     {31'd0, fwd_valid}, 32'd0);

        // ALU writeback
        reset = 1'b0;
        m_pc = 32'h0000_3000;
        drive(1'b1, 1'b1, 5'd5, 2'b00, 32'h1234_5678, 3'd0);
        step();
        check("alu_we",   {31'd0, grf_we}, 32'd1);
        check("alu_a3",   {27'd0, grf_a3}, 32'd5);
        check("alu_wd",   grf_wd, 32'h1234_5678);
        check("alu_fwd",  fwd_data, 32'h1234_5678);
        check("alu_fwda", {27'd0, fwd_addr}, 32'd5);
        check("alu_cnt0", instret, 32'd0);
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 3'd0);
        step();
        check("alu_cnt1", instret, 32'd1);
        check("bub_we",   {31'd0, grf_we}, 32'd0);

        // Load extraction/extension
        m_mem_rdata = 32'h80FF_7F01;
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0000_1000, 3'b001); step();
        check("lb_off0", grf_wd, 32'h0000_0001);
        check("lb_cnt",  instret, 32'd1);
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0000_1001, 3'b001); step();
        check("lb_off1", grf_wd, 32'h0000_007F);
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0000_1002, 3'b001); step();
        check("lb_off2", grf_wd, 32'hFFFF_FFFF);
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0000_1003, 3'b001); step();
        check("lb_off3", grf_wd, 32'hFFFF_FF80);
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0000_1003, 3'b010); step();
        check("lbu_off3", grf_wd, 32'h0000_0080);
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0000_1002, 3'b011); step();
        check("lh_off2", grf_wd, 32'hFFFF_80FF);
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0000_1000, 3'b100); step();
        check("lhu_off0", grf_wd, 32'h0000_7F01);
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0000_1003, 3'b011); step();
        check("lh_off3", grf_wd, 32'hFFFF_80FF);
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0000_1001, 3'b000); step();
        check("lw_off1", grf_wd, 32'h80FF_7F01);
        drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0000_1000, 3'b111); step();
        check("lt7_lw", grf_wd, 32'h80FF_7F01);
        check("ld_cnt", instret, 32'd10);

        // Link value and $0 suppression
        m_pc = 32'h0000_3010;
        drive(1'b1, 1'b1, 5'd31, 2'b10, 32'h0, 3'd0); step();
        check("link_wd", grf_wd, 32'h0000_3018);
        check("link_a3", {27'd0, grf_a3}, 32'd31);
        check("link_pc", grf_pc, 32'h0000_3010);
        check("link_cnt", instret, 32'd11);
        drive(1'b1, 1'b1, 5'd0, 2'b00, 32'hAAAA_5555, 3'd0); step();
        check("r0_we",  {31'd0, grf_we}, 32'd0);
        check("r0_fwd", {31'd0, fwd_valid}, 32'd0);

        // HI/LO into W, then stall for three cycles
        m_hilo_value = 32'hDEAD_BEEF;
        m_pc = 32'h0000_3020;
        drive(1'b1, 1'b1, 5'd7, 2'b11, 32'h0, 3'd0); step();
        check("r0_cnt",  instret, 32'd13);
        check("hilo_wd", grf_wd, 32'hDEAD_BEEF);
        stall = 1'b1;
        m_hilo_value = 32'h0;
        m_pc = 32'h0000_4444;
        drive(1'b1, 1'b1, 5'd9, 2'b00, 32'h1111_1111, 3'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stl_we",  {31'd0, grf_we}, 32'd1);
            check("stl_a3",  {27'd0, grf_a3}, 32'd7);
            check("stl_wd",  grf_wd, 32'hDEAD_BEEF);
            check("stl_pc",  grf_pc, 32'h0000_3020);
            check("stl_cnt", instret, 32'd13);
        end
        flush = 1'b1; step();
        check("sf_we",  {31'd0, grf_we}, 32'd0);
        check("sf_pc",  grf_pc, 32'h0000_3000);
        check("sf_cnt", instret, 32'd13);
        stall = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 3'd0); step();
        check("post_sf_cnt", instret, 32'd13);

        // Counter wrap on the CNT_W=4 copy
        reset = 1'b1; step();
        check("wrap_rst_s", {28'd0, s_instret}, 32'd0);
        check("wrap_rst",   instret, 32'd0);
        reset = 1'b0;
        m_pc = 32'h0000_3100;
        drive(1'b1, 1'b1, 5'd1, 2'b00, 32'h0000_0042, 3'd0);
        for (int i = 0; i < 16; i++) step();
        check("wrap_15", {28'd0, s_instret}, 32'd15);
        step();
        check("wrap_0",   {28'd0, s_instret}, 32'd0);
        check("wrap_big", instret, 32'd16);

        // Reset with a valid instruction in W
        check("pre_rst_we", {31'd0, grf_we}, 32'd1);
        reset = 1'b1; step();
        check("mid_rst_we",  {31'd0, grf_we}, 32'd0);
        check("mid_rst_pc",  grf_pc, 32'h0000_3000);
        check("mid_rst_wd",  grf_wd, 32'd0);
        check("mid_rst_cnt", instret, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
